// File: rtl/latch_seq_if.sv
// Controller-side request/status bundle for the ONFI command/address latch sequencer.
// The master (controller FSM) requests bursts; the slave (sequencer) reports busy/done.
interface latch_seq_if #(
  parameter int DATA_W     = 16,
  parameter int MAX_CYCLES = 5,
  parameter int CNT_W      = 3
);
  logic                         start;
  logic                         latch_type;
  logic [CNT_W-1:0]             count;
  logic [MAX_CYCLES*DATA_W-1:0] data_in;
  logic                         abort;
  logic                         busy;
  logic                         done;

  modport master (
    output start, latch_type, count, data_in, abort,
    input  busy, done
  );

  modport slave (
    input  start, latch_type, count, data_in, abort,
    output busy, done
  );
endinterface

// File: rtl/latch_seq.sv
// ONFI CLE/ALE latch sequencer: one start request issues 1..MAX_CYCLES timed WE# write
// cycles with programmable setup, pulse, gap and hold phases. All pin outputs registered.
module latch_seq #(
  parameter int DATA_W     = 16,
  parameter int MAX_CYCLES = 5,
  parameter int CNT_W      = 3,
  parameter int DLY_W      = 8,
  parameter int T_SETUP    = 1,
  parameter int T_WP       = 2,
  parameter int T_WH       = 2,
  parameter int T_CLH      = 2,
  parameter int T_ALH      = 2
) (
  input  logic              clk,
  input  logic              nreset,
  latch_seq_if.slave        ctl,
  output logic              cle,
  output logic              ale,
  output logic              we_n,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe
);

  // A zero-length phase would never terminate cleanly, so it is stretched to one cycle.
  localparam logic [DLY_W-1:0] L_SETUP = (T_SETUP < 1) ? DLY_W'(1) : DLY_W'(T_SETUP);
  localparam logic [DLY_W-1:0] L_WP    = (T_WP    < 1) ? DLY_W'(1) : DLY_W'(T_WP);
  localparam logic [DLY_W-1:0] L_WH    = (T_WH    < 1) ? DLY_W'(1) : DLY_W'(T_WH);
  localparam logic [DLY_W-1:0] L_CLH   = (T_CLH   < 1) ? DLY_W'(1) : DLY_W'(T_CLH);
  localparam logic [DLY_W-1:0] L_ALH   = (T_ALH   < 1) ? DLY_W'(1) : DLY_W'(T_ALH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_HOLD
  } state_t;

  state_t             state_reg, state_next;
  logic [DLY_W-1:0]   dly_reg, dly_next;
  logic [CNT_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               type_reg, type_next;
  logic [DATA_W-1:0]  data_reg [MAX_CYCLES];

  logic               cle_reg, ale_reg, we_n_reg, dq_oe_reg, busy_reg, done_reg;
  logic [DATA_W-1:0]  dq_out_reg;
  logic               cle_next, ale_next, we_n_next, dq_oe_next, busy_next, done_next;
  logic [DATA_W-1:0]  dq_out_next;

  logic               accept;
  logic               active;
  logic               more_words;
  logic [CNT_W-1:0]   cnt_clamp;
  logic [DLY_W-1:0]   hold_len;
  logic [DATA_W-1:0]  word_next;
  logic [DATA_W-1:0]  in_word [MAX_CYCLES];

  for (genvar gi = 0; gi < MAX_CYCLES; gi++) begin : g_unpack
    assign in_word[gi] = ctl.data_in[gi*DATA_W +: DATA_W];
  end

  assign cnt_clamp  = (ctl.count > CNT_W'(MAX_CYCLES)) ? CNT_W'(MAX_CYCLES) : ctl.count;
  assign hold_len   = type_reg ? L_ALH : L_CLH;
  assign more_words = ((CNT_W+1)'(idx_reg) + (CNT_W+1)'(1)) < (CNT_W+1)'(cnt_reg);

  always_comb begin
    state_next = state_reg;
    dly_next   = dly_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    type_next  = type_reg;
    done_next  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // abort outranks a simultaneous start
        if (ctl.start && !ctl.abort) begin
          accept    = 1'b1;
          type_next = ctl.latch_type;
          cnt_next  = cnt_clamp;
          idx_next  = '0;
          if (cnt_clamp == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = S_SETUP;
            dly_next   = L_SETUP;
          end
        end
      end
      default: begin
        if (ctl.abort) begin
          state_next = S_IDLE;
          dly_next   = '0;
          idx_next   = '0;
        end else if (dly_reg > DLY_W'(1)) begin
          dly_next = dly_reg - DLY_W'(1);
        end else begin
          case (state_reg)
            S_SETUP: begin
              state_next = S_PULSE;
              dly_next   = L_WP;
            end
            S_PULSE: begin
              if (more_words) begin
                state_next = S_GAP;
                dly_next   = L_WH;
              end else begin
                state_next = S_HOLD;
                dly_next   = hold_len;
              end
            end
            S_GAP: begin
              state_next = S_SETUP;
              dly_next   = L_SETUP;
              idx_next   = idx_reg + CNT_W'(1);
            end
            S_HOLD: begin
              state_next = S_IDLE;
              dly_next   = '0;
              idx_next   = '0;
              done_next  = 1'b1;
            end
            default: begin
              state_next = S_IDLE;
              dly_next   = '0;
              idx_next   = '0;
            end
          endcase
        end
      end
    endcase
  end

  // Pins are derived from the upcoming state so they change together with it.
  always_comb begin
    active      = (state_next != S_IDLE);
    word_next   = accept ? in_word[0] : data_reg[idx_next];
    cle_next    = active && !type_next;
    ale_next    = active && type_next;
    we_n_next   = (state_next != S_PULSE);
    dq_oe_next  = active;
    dq_out_next = active ? word_next : '0;
    busy_next   = active;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg  <= S_IDLE;
      dly_reg    <= '0;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      type_reg   <= 1'b0;
      cle_reg    <= 1'b0;
      ale_reg    <= 1'b0;
      we_n_reg   <= 1'b1;
      dq_out_reg <= '0;
      dq_oe_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      for (int i = 0; i < MAX_CYCLES; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      state_reg  <= state_next;
      dly_reg    <= dly_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      type_reg   <= type_next;
      cle_reg    <= cle_next;
      ale_reg    <= ale_next;
      we_n_reg   <= we_n_next;
      dq_out_reg <= dq_out_next;
      dq_oe_reg  <= dq_oe_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      if (accept) begin
        for (int i = 0; i < MAX_CYCLES; i++) begin
          data_reg[i] <= in_word[i];
        end
      end
    end
  end

  assign cle      = cle_reg;
  assign ale      = ale_reg;
  assign we_n     = we_n_reg;
  assign dq_out   = dq_out_reg;
  assign dq_oe    = dq_oe_reg;
  assign ctl.busy = busy_reg;
  assign ctl.done = done_reg;

endmodule
